// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
//   Host-to-board command receiver. Deserializes 8N1 UART bytes from the
//   FTDI RX line and assembles them into checksummed frames
//   A5, CMD, A0, A1, A2, A3, CHK (CHK = CMD^A0^A1^A2^A3, argument
//   little-endian). Each accepted frame produces a one-cycle cmd_valid
//   strobe with an opcode and a 32-bit argument.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   uart_rx         asynchronous serial input, idles high
//   rx_byte         last good byte, valid with rx_byte_valid
//   rx_byte_valid   one-cycle strobe per good byte
//   cmd_code        opcode of last accepted frame (held)
//   cmd_arg         argument of last accepted frame (held)
//   cmd_valid       one-cycle strobe per accepted frame
//   frame_err       one-cycle strobe: stop bit sampled low
//   chk_err         one-cycle strobe: checksum mismatch
//   timeout_err     one-cycle strobe: inter-byte timeout inside a frame
//   dbg_bit_state   current bit-level FSM state
//   dbg_frame_state current frame-level FSM state
//
// Handshake: every output strobe is a single-cycle, registered pulse with
// no back-pressure; the data outputs that accompany a strobe are valid in
// the same cycle as that strobe.
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_CLKS = CLK_FREQ / 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [7:0]  rx_byte,
   output logic        rx_byte_valid,
   output logic [7:0]  cmd_code,
   output logic [31:0] cmd_arg,
   output logic        cmd_valid,
   output logic        frame_err,
   output logic        chk_err,
   output logic        timeout_err,
   output logic [1:0]  dbg_bit_state,
   output logic [2:0]  dbg_frame_state
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT + 1);
   localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]    SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } bit_state_t;

   typedef enum logic [2:0] {
      F_SYNC,
      F_CMD,
      F_ARG0,
      F_ARG1,
      F_ARG2,
      F_ARG3,
      F_CHK
   } frame_state_t;

   // input synchronizer
   logic rx_meta_q, rx_meta_d;
   logic rxs_q, rxs_d;

   // bit-level receiver
   bit_state_t    bit_state_q, bit_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_byte_valid_q, rx_byte_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          byte_done;
   logic          byte_bad;

   // frame-level assembler
   frame_state_t  frame_state_q, frame_state_d;
   logic [7:0]    chk_acc_q, chk_acc_d;
   logic [7:0]    code_stage_q, code_stage_d;
   logic [31:0]   arg_stage_q, arg_stage_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    cmd_code_q, cmd_code_d;
   logic [31:0]   cmd_arg_q, cmd_arg_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          chk_err_q, chk_err_d;
   logic          timeout_err_q, timeout_err_d;

   // -----------------------------------------------------------------------
   // Synchronizer
   // -----------------------------------------------------------------------
   always_comb begin
      rx_meta_d = uart_rx;
      rxs_d     = rx_meta_q;
   end

   // -----------------------------------------------------------------------
   // Bit FSM: next state and byte-level outputs
   // -----------------------------------------------------------------------
   always_comb begin
      bit_state_d     = bit_state_q;
      cnt_d           = cnt_q;
      bit_idx_d       = bit_idx_q;
      shift_d         = shift_q;
      rx_byte_d       = rx_byte_q;
      rx_byte_valid_d = 1'b0;
      frame_err_d     = 1'b0;
      byte_done       = 1'b0;
      byte_bad        = 1'b0;

      case (bit_state_q)
         B_IDLE: begin
            if (!rxs_q) begin
               bit_state_d = B_START;
               cnt_d       = '0;
            end
         end
         B_START: begin
            if (cnt_q == HALF_LAST) begin
               // Mid-start resample: a high line means a glitch.
               cnt_d       = '0;
               bit_idx_d   = '0;
               bit_state_d = rxs_q ? B_IDLE : B_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         B_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rxs_q, shift_q[7:1]};  // LSB arrives first
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) begin
                  bit_state_d = B_STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         B_STOP: begin
            if (cnt_q == BIT_LAST) begin
               // Back to IDLE at the sample itself so an immediately
               // following start bit is not missed.
               cnt_d       = '0;
               bit_state_d = B_IDLE;
               if (rxs_q) begin
                  byte_done       = 1'b1;
                  rx_byte_d       = shift_q;
                  rx_byte_valid_d = 1'b1;
               end else begin
                  byte_bad    = 1'b1;
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: bit_state_d = B_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // Frame FSM: works on the byte-complete event so that cmd_valid/chk_err
   // register in the same cycle as rx_byte_valid of the CHK byte.
   // -----------------------------------------------------------------------
   always_comb begin
      frame_state_d = frame_state_q;
      chk_acc_d     = chk_acc_q;
      code_stage_d  = code_stage_q;
      arg_stage_d   = arg_stage_q;
      tmo_d         = tmo_q;
      cmd_code_d    = cmd_code_q;
      cmd_arg_d     = cmd_arg_q;
      cmd_valid_d   = 1'b0;
      chk_err_d     = 1'b0;
      timeout_err_d = 1'b0;

      if (frame_state_q == F_SYNC) begin
         tmo_d = '0;
         if (byte_done && (shift_q == SYNC_BYTE)) begin
            frame_state_d = F_CMD;
            chk_acc_d     = '0;
         end
      end else if (byte_bad) begin
         frame_state_d = F_SYNC;
         tmo_d         = '0;
      end else if (byte_done) begin
         tmo_d     = '0;
         chk_acc_d = chk_acc_q ^ shift_q;
         case (frame_state_q)
            F_CMD: begin
               code_stage_d  = shift_q;
               frame_state_d = F_ARG0;
            end
            F_ARG0: begin
               arg_stage_d[7:0] = shift_q;
               frame_state_d    = F_ARG1;
            end
            F_ARG1: begin
               arg_stage_d[15:8] = shift_q;
               frame_state_d     = F_ARG2;
            end
            F_ARG2: begin
               arg_stage_d[23:16] = shift_q;
               frame_state_d      = F_ARG3;
            end
            F_ARG3: begin
               arg_stage_d[31:24] = shift_q;
               frame_state_d      = F_CHK;
            end
            F_CHK: begin
               if (shift_q == chk_acc_q) begin
                  cmd_code_d  = code_stage_q;
                  cmd_arg_d   = arg_stage_q;
                  cmd_valid_d = 1'b1;
               end else begin
                  chk_err_d = 1'b1;
               end
               frame_state_d = F_SYNC;
            end
            default: frame_state_d = F_SYNC;
         endcase
      end else if (tmo_q == TMO_LAST) begin
         // This cycle is the TIMEOUT_CLKS-th idle clock since the last byte.
         timeout_err_d = 1'b1;
         frame_state_d = F_SYNC;
         tmo_d         = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q       <= 1'b1;
         rxs_q           <= 1'b1;
         bit_state_q     <= B_IDLE;
         cnt_q           <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         rx_byte_q       <= '0;
         rx_byte_valid_q <= 1'b0;
         frame_err_q     <= 1'b0;
         frame_state_q   <= F_SYNC;
         chk_acc_q       <= '0;
         code_stage_q    <= '0;
         arg_stage_q     <= '0;
         tmo_q           <= '0;
         cmd_code_q      <= '0;
         cmd_arg_q       <= '0;
         cmd_valid_q     <= 1'b0;
         chk_err_q       <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         rx_meta_q       <= rx_meta_d;
         rxs_q           <= rxs_d;
         bit_state_q     <= bit_state_d;
         cnt_q           <= cnt_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         rx_byte_q       <= rx_byte_d;
         rx_byte_valid_q <= rx_byte_valid_d;
         frame_err_q     <= frame_err_d;
         frame_state_q   <= frame_state_d;
         chk_acc_q       <= chk_acc_d;
         code_stage_q    <= code_stage_d;
         arg_stage_q     <= arg_stage_d;
         tmo_q           <= tmo_d;
         cmd_code_q      <= cmd_code_d;
         cmd_arg_q       <= cmd_arg_d;
         cmd_valid_q     <= cmd_valid_d;
         chk_err_q       <= chk_err_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign rx_byte         = rx_byte_q;
   assign rx_byte_valid   = rx_byte_valid_q;
   assign cmd_code        = cmd_code_q;
   assign cmd_arg         = cmd_arg_q;
   assign cmd_valid       = cmd_valid_q;
   assign frame_err       = frame_err_q;
   assign chk_err         = chk_err_q;
   assign timeout_err     = timeout_err_q;
   assign dbg_bit_state   = bit_state_q;
   assign dbg_frame_state = frame_state_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
//   Directed plus randomized frames driven onto uart_rx. A frame-level
//   reference model (byte queue, XOR over the payload) predicts every good
//   byte, accepted command and error strobe; a negedge monitor collects what
//   the receiver actually produced.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = CLK_FREQ / BAUD;   // 16 clocks per bit
   localparam int HALF     = CPB / 2;
   localparam int TMO      = 1000;
   localparam int CLK_T    = 10;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        uart_rx;
   logic [7:0]  rx_byte;
   logic        rx_byte_valid;
   logic [7:0]  cmd_code;
   logic [31:0] cmd_arg;
   logic        cmd_valid;
   logic        frame_err;
   logic        chk_err;
   logic        timeout_err;
   logic [1:0]  dbg_bit_state;
   logic [2:0]  dbg_frame_state;

   always #(CLK_T / 2) clk = ~clk;

   uart_cmd_rx #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUD         (BAUD),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .uart_rx         (uart_rx),
      .rx_byte         (rx_byte),
      .rx_byte_valid   (rx_byte_valid),
      .cmd_code        (cmd_code),
      .cmd_arg         (cmd_arg),
      .cmd_valid       (cmd_valid),
      .frame_err       (frame_err),
      .chk_err         (chk_err),
      .timeout_err     (timeout_err),
      .dbg_bit_state   (dbg_bit_state),
      .dbg_frame_state (dbg_frame_state)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor (observed side) ----------------
   logic [7:0]  got_byte_q[$];
   int          byte_cyc_q[$];
   logic [39:0] got_cmd_q[$];
   int          cmd_cyc_q[$];
   int          n_chk = 0;
   int          n_frm = 0;
   int          n_tmo = 0;
   int          n_multi = 0;

   always @(negedge clk) begin
      if (rx_byte_valid === 1'b1) begin
         got_byte_q.push_back(rx_byte);
         byte_cyc_q.push_back(cyc);
      end
      if (cmd_valid === 1'b1) begin
         got_cmd_q.push_back({cmd_code, cmd_arg});
         cmd_cyc_q.push_back(cyc);
      end
      if (chk_err === 1'b1) n_chk++;
      if (frame_err === 1'b1) n_frm++;
      if (timeout_err === 1'b1) n_tmo++;
      if ((int'(cmd_valid) + int'(chk_err) + int'(frame_err) + int'(timeout_err)) > 1)
         n_multi++;
   end

   // ---------------- reference model (expected side) ----------------
   logic [7:0]  exp_byte_q[$];
   logic [39:0] exp_cmd_q[$];
   logic [7:0]  frm_q[$];
   logic [7:0]  exp_code = 8'h00;
   logic [31:0] exp_arg  = 32'h0;
   int          e_chk = 0;
   int          e_frm = 0;
   int          e_tmo = 0;

   int tests = 0;
   int fails = 0;
   int rd_b  = 0;
   int rd_c  = 0;
   int bit_t = CPB * CLK_T;

   function automatic logic [7:0] chk_of(input logic [7:0] code, input logic [31:0] arg);
      return code ^ arg[7:0] ^ arg[15:8] ^ arg[23:16] ^ arg[31:24];
   endfunction

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] x;
      exp_byte_q.push_back(b);
      if (frm_q.size() == 0) begin
         if (b == 8'hA5) frm_q.push_back(b);
      end else begin
         frm_q.push_back(b);
         if (frm_q.size() == 7) begin
            x = frm_q[1] ^ frm_q[2] ^ frm_q[3] ^ frm_q[4] ^ frm_q[5];
            if (x == frm_q[6]) begin
               exp_code = frm_q[1];
               exp_arg  = {frm_q[5], frm_q[4], frm_q[3], frm_q[2]};
               exp_cmd_q.push_back({exp_code, exp_arg});
            end else begin
               e_chk++;
            end
            frm_q.delete();
         end
      end
   endtask

   task automatic model_frame_err();
      e_frm++;
      frm_q.delete();
   endtask

   // ---------------- comparison helpers ----------------
   task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_sb(input string tag);
      chk_int({tag, " byte_count"}, got_byte_q.size(), exp_byte_q.size());
      for (int i = rd_b; i < exp_byte_q.size() && i < got_byte_q.size(); i++)
         chk_vec({tag, " rx_byte"}, 64'(got_byte_q[i]), 64'(exp_byte_q[i]));
      rd_b = exp_byte_q.size();
      chk_int({tag, " cmd_count"}, got_cmd_q.size(), exp_cmd_q.size());
      for (int i = rd_c; i < exp_cmd_q.size() && i < got_cmd_q.size(); i++)
         chk_vec({tag, " cmd_code_arg"}, 64'(got_cmd_q[i]), 64'(exp_cmd_q[i]));
      rd_c = exp_cmd_q.size();
      chk_int({tag, " chk_err_count"}, n_chk, e_chk);
      chk_int({tag, " frame_err_count"}, n_frm, e_frm);
      chk_int({tag, " timeout_err_count"}, n_tmo, e_tmo);
      chk_vec({tag, " held_cmd"}, 64'({cmd_code, cmd_arg}), 64'({exp_code, exp_arg}));
   endtask

   // ---------------- drivers ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      wait_clks(n);
      if (n > TMO && frm_q.size() > 0) begin
         e_tmo++;
         frm_q.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      uart_rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         #(bit_t);
      end
      uart_rx = stop_ok;
      #(bit_t);
      uart_rx = 1'b1;
      if (stop_ok) model_byte(b);
      else model_frame_err();
   endtask

   task automatic send_frame(input logic [7:0] code, input logic [31:0] arg,
                             input logic [7:0] chk, input int gap);
      logic [7:0] bytes [7];
      bytes[0] = 8'hA5;
      bytes[1] = code;
      bytes[2] = arg[7:0];
      bytes[3] = arg[15:8];
      bytes[4] = arg[23:16];
      bytes[5] = arg[31:24];
      bytes[6] = chk;
      for (int i = 0; i < 7; i++) begin
         send_byte(bytes[i], 1'b1);
         if (gap > 0 && i < 6) wait_clks(gap);
      end
   endtask

   task automatic model_reset();
      frm_q.delete();
      exp_code = 8'h00;
      exp_arg  = 32'h0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  code;
      logic [31:0] arg;
      logic [7:0]  chk;
      int          t0;
      int          b0;
      int          lat;
      int          diff;
      int          r;

      rst     = 1'b1;
      uart_rx = 1'b1;
      wait_clks(3);
      chk_vec("reset outputs",
              64'({rx_byte, rx_byte_valid, cmd_code, cmd_arg, cmd_valid,
                   frame_err, chk_err, timeout_err, dbg_bit_state, dbg_frame_state}),
              64'h0);
      rst = 1'b0;
      wait_clks(5);

      // Valid frame; the checksum is the XOR rule applied to 01 78 56 34 12.
      wait_clks(1);
      t0 = cyc;
      b0 = got_byte_q.size();
      send_frame(8'h01, 32'h1234_5678, chk_of(8'h01, 32'h1234_5678), 0);
      wait_clks(4);
      check_sb("valid_frame");
      lat = (byte_cyc_q.size() > b0) ? (byte_cyc_q[b0] - t0) : -1;
      tests++;
      assert (lat >= 2 + HALF + 9 * CPB && lat <= 2 + HALF + 9 * CPB + 2) else begin
         fails++;
         $error("FAIL byte_latency: got %0d clocks expected %0d +-1", lat, 2 + HALF + 9 * CPB + 1);
      end

      // Bad checksum: outputs keep the previous frame.
      send_frame(8'h01, 32'h1234_5678, 8'h3C, 0);
      wait_clks(4);
      check_sb("bad_checksum");

      // Short glitch: nothing at all should come out.
      uart_rx = 1'b0;
      wait_clks(4);
      uart_rx = 1'b1;
      wait_clks(40);
      check_sb("glitch");

      // Stop bit forced low.
      send_byte(8'h55, 1'b0);
      wait_clks(40);
      check_sb("framing");

      // Timeout mid-frame, then recovery.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      idle(TMO + 10);
      check_sb("timeout");
      arg = $urandom;
      send_frame(8'h02, arg, chk_of(8'h02, arg), 3);
      wait_clks(4);
      check_sb("after_timeout");

      // Garbage byte then two frames with zero gap.
      send_byte(8'h00, 1'b1);
      arg = $urandom;
      send_frame(8'h10, arg, chk_of(8'h10, arg), 0);
      arg = $urandom;
      send_frame(8'h11, arg, chk_of(8'h11, arg), 0);
      wait_clks(4);
      check_sb("back_to_back");
      diff = (cmd_cyc_q.size() >= 2) ?
             (cmd_cyc_q[cmd_cyc_q.size() - 1] - cmd_cyc_q[cmd_cyc_q.size() - 2]) : -1;
      tests++;
      assert (diff >= 70 * CPB - 1 && diff <= 70 * CPB + 1) else begin
         fails++;
         $error("FAIL b2b_spacing: got %0d clocks expected %0d +-1", diff, 70 * CPB);
      end

      // Reset in the middle of a frame.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h11, 1'b1);
      wait_clks(2);
      check_sb("pre_reset");
      rst = 1'b1;
      wait_clks(1);
      chk_vec("mid_frame_reset outputs",
              64'({rx_byte, rx_byte_valid, cmd_code, cmd_arg, cmd_valid,
                   frame_err, chk_err, timeout_err, dbg_bit_state, dbg_frame_state}),
              64'h0);
      rst = 1'b0;
      model_reset();
      wait_clks(5);
      arg = $urandom;
      send_frame(8'h04, arg, chk_of(8'h04, arg), 2);
      wait_clks(4);
      check_sb("after_reset");

      // Baud mismatch of about +/-2%.
      bit_t = CPB * CLK_T + 3;
      arg = $urandom;
      send_frame(8'h20, arg, chk_of(8'h20, arg), 5);
      wait_clks(20);
      bit_t = CPB * CLK_T - 3;
      arg = $urandom;
      send_frame(8'h21, arg, chk_of(8'h21, arg), 0);
      wait_clks(20);
      bit_t = CPB * CLK_T;
      check_sb("baud_tolerance");

      // Randomized frames mixed with garbage and framing errors.
      for (int k = 0; k < 14; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            send_byte(8'($urandom_range(0, 255)), 1'b1);
         end else if (r == 1) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0);
            idle(30);
         end
         code = 8'($urandom_range(0, 255));
         arg  = $urandom;
         chk  = chk_of(code, arg);
         if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
         send_frame(code, arg, chk, $urandom_range(0, 12));
         wait_clks(4);
         check_sb("random");
      end
      idle(TMO + 10);
      check_sb("random_flush");

      chk_int("exclusive_strobes", n_multi, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
